// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// Included by dmem_array, dmem_responder and their interface users.
package dmem_pkg;

  localparam int WORD_W   = 32;
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_stall
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write, asynchronous read.
// Kept separate so it can be swapped for an SRAM macro.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: wait states, range/alignment check.
// DMEM_POSTED_WRITE_EN: stores bypass the wait states.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int WC    = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES;
  localparam logic [3:0] WAIT_INIT = (WC == 0) ? 4'd0 : 4'(WC - 1);

`ifdef DMEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  dmem_state_t       state, state_d;
  logic [3:0]        cnt, cnt_d;
  dmem_req_t         req_q, cur;
  logic              err, wr_en, to_resp, accept;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] rd_word;
  logic              rsp_valid_q, rsp_err_q;
  logic [WORD_W-1:0] rsp_rdata_q;

  // In IDLE the live request is used so zero-wait and posted paths
  // can complete at the accepting edge.
  always_comb begin
    cur = req_q;
    if (state == IDLE) begin
      cur.we    = bus.req_we;
      cur.addr  = bus.req_addr;
      cur.wdata = bus.req_wdata;
    end
  end

  assign err = (|cur.addr[1:0]) | (|cur.addr[WORD_W-1:IDX_W+2]);
  assign idx = cur.addr[IDX_W+1:2];

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    to_resp = 1'b0;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WC == 0 || (POSTED && bus.req_we)) begin
            state_d = RESP;
            to_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_d = RESP;
          to_resp = 1'b1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_en = to_resp & cur.we & ~err & reset;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (CLK),
    .we    (wr_en),
    .idx   (idx),
    .wdata (cur.wdata),
    .rdata (rd_word)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      rsp_valid_q <= to_resp;
      if (accept) req_q <= cur;
      if (to_resp) begin
        rsp_rdata_q <= (!cur.we && !err) ? rd_word : '0;
        rsp_err_q   <= err;
      end
    end
  end

  assign bus.req_ready = (state == IDLE) & reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_stall = bus.req_valid & ~rsp_valid_q;

endmodule
